// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: fetch/data two-port arbiter onto a 16-bit, byte-laned memory;
// data byte stores are done as a read-modify-write of the containing word.
// Rev 1.0
// ============================================================================
module mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        o_if_ack,
    output logic [15:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic        i_d_byte,
    input  logic [15:0] i_d_addr,
    input  logic [15:0] i_d_wdata,
    output logic        o_d_ack,
    output logic [15:0] o_d_rdata,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata_high,
    output logic [7:0]  o_mem_wdata_low,
    input  logic [7:0]  i_mem_rdata_high,
    input  logic [7:0]  i_mem_rdata_low
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_ACK    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rsp;
    logic [15:0] r_word;
    logic        r_we;
    logic        r_byte;
    logic        r_gnt_d;
    logic        r_last_d;
    logic        w_any_req;
    logic        w_pick_d;
    logic        w_we;
    logic [15:0] w_mem_rd;
    logic [15:0] w_rd_result;
    logic [15:0] w_word_addr;

    assign w_any_req   = i_if_req | i_d_req;
    // Data wins if alone, under fixed priority, or when fetch was served last.
    assign w_pick_d    = i_d_req & (~i_if_req | FIXED_PRIO | ~r_last_d);
    assign w_mem_rd    = {i_mem_rdata_high, i_mem_rdata_low};
    assign w_word_addr = {r_addr[15:1], 1'b0};
    assign w_rd_result = r_byte ? {8'h00, (r_addr[0] ? i_mem_rdata_high : i_mem_rdata_low)}
                                : w_mem_rd;
    // Gating with reset keeps a write in flight at a reset edge from landing.
    assign o_mem_we    = w_we & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_we             = 1'b0;
        o_mem_addr       = 16'h0000;
        o_mem_wdata_high = 8'h00;
        o_mem_wdata_low  = 8'h00;
        o_if_ack         = 1'b0;
        o_d_ack          = 1'b0;
        o_if_rdata       = 16'h0000;
        o_d_rdata        = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    if (w_pick_d && i_d_we) begin
                        w_next = i_d_byte ? S_RMW_RD : S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD: begin
                o_mem_addr = w_word_addr;
                w_next     = S_ACK;
            end
            S_WR: begin
                o_mem_addr       = w_word_addr;
                w_we             = 1'b1;
                o_mem_wdata_high = r_wdata[15:8];
                o_mem_wdata_low  = r_wdata[7:0];
                w_next           = S_ACK;
            end
            S_RMW_RD: begin
                o_mem_addr = w_word_addr;
                w_next     = S_RMW_WR;
            end
            S_RMW_WR: begin
                o_mem_addr       = w_word_addr;
                w_we             = 1'b1;
                o_mem_wdata_high = r_addr[0] ? r_wdata[7:0] : r_word[15:8];
                o_mem_wdata_low  = r_addr[0] ? r_word[7:0]  : r_wdata[7:0];
                w_next           = S_ACK;
            end
            S_ACK: begin
                o_if_ack   = ~r_gnt_d;
                o_d_ack    = r_gnt_d;
                o_if_rdata = r_gnt_d ? 16'h0000 : r_rsp;
                o_d_rdata  = r_gnt_d ? r_rsp : 16'h0000;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr   <= 16'h0000;
            r_wdata  <= 16'h0000;
            r_rsp    <= 16'h0000;
            r_word   <= 16'h0000;
            r_we     <= 1'b0;
            r_byte   <= 1'b0;
            r_gnt_d  <= 1'b0;
            r_last_d <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_d  <= w_pick_d;
                        r_last_d <= w_pick_d;
                        r_rsp    <= 16'h0000;
                        if (w_pick_d) begin
                            r_addr  <= i_d_addr;
                            r_we    <= i_d_we;
                            r_byte  <= i_d_byte;
                            r_wdata <= i_d_wdata;
                        end else begin
                            r_addr  <= i_if_addr;
                            r_we    <= 1'b0;
                            r_byte  <= 1'b0;
                            r_wdata <= 16'h0000;
                        end
                    end
                end
                S_RD:     r_rsp  <= w_rd_result;
                S_RMW_RD: r_word <= w_mem_rd;
                default: ;
            endcase
        end
    end

    // r_we is kept for visibility of the latched request; routing uses the FSM path.
    logic w_unused;
    assign w_unused = r_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Bench for mem_arbiter: table-driven single transactions against a byte-laned
// memory model, plus hand sequences for arbitration and reset abort.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req, d_req, d_we, d_byte;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_we;
    logic [15:0] if_rdata, d_rdata, mem_addr;
    logic [7:0]  mem_wh, mem_wl, mem_rh, mem_rl;

    logic        if2_req, d2_req, if2_ack, d2_ack, mem2_we;
    logic [15:0] if2_addr, d2_addr, if2_rdata, d2_rdata, mem2_addr;
    logic [7:0]  mem2_wh, mem2_wl, mem2_rh, mem2_rl;

    logic [15:0] mem [0:32767];
    logic        pre_we;
    logic [14:0] pre_idx;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[15:1]] <= {mem_wh, mem_wl};
        else if (pre_we) mem[pre_idx] <= pre_data;
    end
    assign mem_rh  = mem[mem_addr[15:1]][15:8];
    assign mem_rl  = mem[mem_addr[15:1]][7:0];
    assign mem2_rh = 8'hC3;
    assign mem2_rl = mem2_addr[7:0];

    mem_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_byte(d_byte), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_ack(d_ack), .o_d_rdata(d_rdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_wdata_high(mem_wh), .o_mem_wdata_low(mem_wl),
        .i_mem_rdata_high(mem_rh), .i_mem_rdata_low(mem_rl)
    );

    mem_arbiter #(.FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if2_req), .i_if_addr(if2_addr), .o_if_ack(if2_ack), .o_if_rdata(if2_rdata),
        .i_d_req(d2_req), .i_d_we(1'b0), .i_d_byte(1'b0), .i_d_addr(d2_addr),
        .i_d_wdata(16'h0000), .o_d_ack(d2_ack), .o_d_rdata(d2_rdata),
        .o_mem_addr(mem2_addr), .o_mem_we(mem2_we),
        .o_mem_wdata_high(mem2_wh), .o_mem_wdata_low(mem2_wl),
        .i_mem_rdata_high(mem2_rh), .i_mem_rdata_low(mem2_rl)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        bit          bt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [15:0] exp_word;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          is_d;
        bit          chk_rd;
        logic [15:0] rdata;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int          cyc;
        int          we_cnt;
        bit          got;
        logic [15:0] ma1;
        logic [31:0] rd_idle;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_byte = v.bt; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        e.is_d = v.is_d; e.chk_rd = !v.we; e.rdata = v.exp_rdata; e.lat = v.exp_lat;
        sbq.push_back(e);
        cyc = 0; we_cnt = 0; got = 1'b0; ma1 = 16'h0; rd_idle = 32'h0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (mem_we) we_cnt++;
            if (cyc == 1) begin
                ma1     = mem_addr;
                rd_idle = {if_rdata, d_rdata};
            end
            if (if_ack || d_ack) got = 1'b1;
        end
        if (!got) begin
            chk($sformatf("v%0d_ack_timeout", idx), 32'd0, 32'd1);
            sbq.delete();
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d_acks", idx), {30'd0, if_ack, d_ack}, {30'd0, !e.is_d, e.is_d});
            chk($sformatf("v%0d_latency", idx), cyc, e.lat);
            if (e.chk_rd)
                chk($sformatf("v%0d_rdata", idx), e.is_d ? d_rdata : if_rdata, e.rdata);
            chk($sformatf("v%0d_other_rdata", idx), e.is_d ? if_rdata : d_rdata, 32'd0);
        end
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_rdata_noack", idx), rd_idle, 32'd0);
        chk($sformatf("v%0d_mem_addr", idx), ma1, {v.addr[15:1], 1'b0});
        chk($sformatf("v%0d_we_cycles", idx), we_cnt, v.we ? 1 : 0);
        chk($sformatf("v%0d_mem_word", idx), mem[v.addr[15:1]], v.exp_word);
    endtask

    vec_t vecs[12];
    exp_t e;
    int   acks, cyc, we_cnt, ov;

    initial begin
        //          is_d we bt addr      wdata     rdata     word      lat
        vecs[0]  = '{1'b0, 0, 0, 16'h000D, 16'h0000, 16'h1234, 16'h1234, 2};
        vecs[1]  = '{1'b1, 0, 1, 16'h000D, 16'h0000, 16'h0012, 16'h1234, 2};
        vecs[2]  = '{1'b1, 0, 1, 16'h000C, 16'h0000, 16'h0034, 16'h1234, 2};
        vecs[3]  = '{1'b1, 0, 0, 16'h000D, 16'h0000, 16'h1234, 16'h1234, 2};
        vecs[4]  = '{1'b1, 1, 1, 16'h000D, 16'h00AB, 16'h0000, 16'hAB34, 3};
        vecs[5]  = '{1'b0, 0, 0, 16'h000C, 16'h0000, 16'hAB34, 16'hAB34, 2};
        vecs[6]  = '{1'b1, 1, 1, 16'h000C, 16'h55CD, 16'h0000, 16'hABCD, 3};
        vecs[7]  = '{1'b1, 0, 1, 16'h000D, 16'h0000, 16'h00AB, 16'hABCD, 2};
        vecs[8]  = '{1'b1, 1, 0, 16'h0020, 16'hBEEF, 16'h0000, 16'hBEEF, 2};
        vecs[9]  = '{1'b1, 0, 0, 16'h0021, 16'h0000, 16'hBEEF, 16'hBEEF, 2};
        vecs[10] = '{1'b1, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 2};
        vecs[11] = '{1'b0, 0, 0, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 2};

        rst_n = 1'b0;
        if_req = 0; d_req = 0; d_we = 0; d_byte = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        if2_req = 0; d2_req = 0; if2_addr = 0; d2_addr = 0;
        pre_we = 1'b1; pre_idx = 15'd6; pre_data = 16'h1234;
        @(negedge clk);
        pre_we = 1'b0;
        @(negedge clk);
        chk("rst_acks", {if_ack, d_ack}, 32'd0);
        chk("rst_mem_we", mem_we, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wdata", {mem_wh, mem_wl}, 32'd0);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Both ports held from reset: data first, then strict alternation.
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 16'h000C;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            e.is_d = (i % 2 == 0); e.chk_rd = 1'b1;
            e.rdata = e.is_d ? 16'hBEEF : 16'hFFFF; e.lat = 0;
            sbq.push_back(e);
        end
        if_addr = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0; cyc = 0; ov = 0; we_cnt = 0;
        while (acks < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_ack && d_ack) ov++;
            if (mem_we) we_cnt++;
            if ((if_ack || d_ack) && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("rr%0d_port", acks), {if_ack, d_ack}, {30'd0, !e.is_d, e.is_d});
                chk($sformatf("rr%0d_rdata", acks), e.is_d ? d_rdata : if_rdata, e.rdata);
                acks++;
                if (acks == 6) begin if_req = 1'b0; d_req = 1'b0; end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("rr_ack_count", acks, 32'd6);
        chk("rr_overlap", ov, 32'd0);
        chk("rr_no_write", we_cnt, 32'd0);
        sbq.delete();
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) acks++;
        end
        chk("rr_no_extra_ack", acks, 32'd0);

        // Reset during RMW_RD of a byte write aborts it.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'h0000; d_wdata = 16'h0011;
        @(negedge clk);
        rst_n = 1'b0; d_req = 1'b0;
        acks = 0; we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_n = 1'b1;
            @(negedge clk);
            if (d_ack || if_ack) acks++;
            if (mem_we) we_cnt++;
        end
        chk("rmw_abort_ack", acks, 32'd0);
        chk("rmw_abort_we", we_cnt, 32'd0);
        chk("rmw_abort_word", mem[0], 32'h0000FFFF);

        // Reset landing on the WR edge must suppress the write.
        d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 16'h0000; d_wdata = 16'h1111;
        @(negedge clk);
        chk("wr_state_we", mem_we, 32'd1);
        rst_n = 1'b0; d_req = 1'b0;
        #1;
        chk("wr_reset_we_gated", mem_we, 32'd0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst_n = 1'b1;
            @(negedge clk);
            if (d_ack || if_ack) acks++;
        end
        chk("wr_abort_ack", acks, 32'd0);
        chk("wr_abort_word", mem[0], 32'h0000FFFF);

        // Fixed priority: data wins every time while held.
        @(negedge clk);
        if2_req = 1'b1; if2_addr = 16'h0010;
        d2_req = 1'b1; d2_addr = 16'h0020;
        acks = 0; cyc = 0; ov = 0;
        while (acks < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (if2_ack) ov++;
            if (d2_ack) begin
                acks++;
                if (acks == 4) d2_req = 1'b0;
            end
        end
        chk("fp_data_acks", acks, 32'd4);
        chk("fp_fetch_starved", ov, 32'd0);
        cyc = 0;
        while (!if2_ack && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("fp_fetch_after_drop", if2_ack, 32'd1);
        chk("fp_fetch_rdata", if2_rdata, 32'h0000C310);
        if2_req = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = data port always wins ties.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 if_req  input  1  fetch-port request (read-only, word).
REQ-005 if_addr  input  16  fetch byte address; bit 0 ignored.
REQ-006 if_ack  output  1  one-cycle pulse, fetch transaction complete.
REQ-007 if_rdata  output  16  fetch word, valid while if_ack=1.
REQ-008 d_req  input  1  data-port request.
REQ-009 d_we  input  1  1 = write, 0 = read.
REQ-010 d_byte  input  1  1 = byte access, 0 = word access.
REQ-011 d_addr  input  16  data byte address; bit 0 selects byte for byte access, ignored for word access.
REQ-012 d_wdata  input  16  write data; byte writes use d_wdata[7:0].
REQ-013 d_ack  output  1  one-cycle pulse, data transaction complete.
REQ-014 d_rdata  output  16  read result, valid while d_ack=1; byte reads zero-extended.
REQ-015 mem_addr  output  16  memory address, always even.
REQ-016 mem_we  output  1  memory write enable; write takes effect on the rising edge.
REQ-017 mem_wdata_high / mem_wdata_low  output  8 each  memory write bytes.
REQ-018 mem_rdata_high / mem_rdata_low  input  8 each  asynchronous memory read bytes for mem_addr.

Function
REQ-019 Byte order: low byte = even address, high byte = odd address.
REQ-020 FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, ACK.
REQ-021 IDLE: if any req is high, arbitrate and latch the winner's address/we/byte/wdata into internal registers; else stay in IDLE.
REQ-022 Next state from IDLE: fetch or data read -> RD; data word write -> WR; data byte write -> RMW_RD.
REQ-023 Round-robin: on simultaneous requests, grant the port not granted last; single requester always wins.
REQ-024 RD: drive mem_addr = {addr[15:1],0}, mem_we=0; capture read data into the response register at end of cycle; -> ACK.
REQ-025 Byte read result: addr[0]=0 -> {8'h00, low}; addr[0]=1 -> {8'h00, high}.
REQ-026 WR: mem_we=1, mem_wdata_high/low = wdata[15:8]/[7:0]; -> ACK.
REQ-027 RMW_RD: mem_we=0; capture the word; -> RMW_WR.
REQ-028 RMW_WR: mem_we=1; write the captured word with only the selected byte replaced by wdata[7:0]; -> ACK.
REQ-029 ACK: assert exactly one of if_ack/d_ack for one cycle; drive the response data; ignore requests; -> IDLE.
REQ-030 Latency from req sampled in IDLE to ack: read/word write = 2 cycles; byte write = 3 cycles.
REQ-031 Requesters hold req and fields stable until ack; req held past the ack cycle is treated as a new request in the next IDLE.
REQ-032 mem_we is 1 only in WR and RMW_WR; mem_addr = 0 and mem_wdata = 0 in IDLE.
REQ-033 Outputs if_rdata/d_rdata are 0 when their ack is 0.

Reset
REQ-034 While rst_n=0 at a rising edge: state <- IDLE, all acks 0, mem_we 0, mem_addr 0, write data 0, response registers 0, last-grant <- fetch.
REQ-035 Reset mid-transaction aborts it: no ack is issued and mem_we is 0 from the next edge; a write in flight at that edge is not performed.

Verification
REQ-036 Preload mem[0x000C]=0x34, mem[0x000D]=0x12; fetch if_addr=0x000D -> if_ack 2 cycles later, if_rdata=0x1234, mem_addr=0x000C.
REQ-037 Data byte read d_addr=0x000D -> d_rdata=0x0012; d_addr=0x000C -> d_rdata=0x0034.
REQ-038 Byte write d_addr=0x000D, d_wdata=0x00AB over word 0x1234 -> mem_we high 1 cycle, memory word 0xAB34, d_ack 3 cycles after req.
REQ-039 if_req and d_req both held from reset, FIXED_PRIO=0 -> grants alternate data, fetch, data, ...; exactly one ack per transaction; no ack overlaps.
REQ-040 Word write 0xFFFF to 0x0000, then rst_n=0 asserted during RMW_RD of a subsequent byte write -> no d_ack, mem_we never high, memory word still 0xFFFF.
REQ-041 FIXED_PRIO=1 with both requests held -> data port granted every transaction and fetch never acked until d_req drops.
